// File: rtl/sync_pkg.sv
// Shared types and default timing values for the frame-synchronised trigger sequencer.
package sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_FG_WAIT = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } sync_state_e;

  localparam int unsigned FG_DELAY_DEF       = 10_000_000;
  localparam int unsigned TRIGGER_DELAY_DEF  = 350_000;
  localparam int unsigned DETECTOR_DELAY_DEF = 5;

endpackage

// File: rtl/sync_pulse_ch.sv
// One trigger channel: waits delay_i cycles after t0, then drives a width_i-cycle pulse.
module sync_pulse_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] width_i,
  output logic             pulse_o,
  output logic             finished_o
);

  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic             out_q, out_d;

  // dly_q/wid_q describe the current cycle: cycles still to wait, then pulse cycles left
  // including this one. A zero width loads both as zero so the channel is finished at t0.
  always_comb begin
    dly_d = '0;
    wid_d = '0;
    if (load_i) begin
      if (width_i != '0) begin
        dly_d = delay_i;
        wid_d = width_i;
      end
    end else if (run_i) begin
      dly_d = dly_q;
      wid_d = wid_q;
      if (dly_q != '0) begin
        dly_d = dly_q - CNT_W'(1);
      end else if (wid_q != '0) begin
        wid_d = wid_q - CNT_W'(1);
      end
    end
    out_d = (load_i || run_i) && (dly_d == '0) && (wid_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dly_q <= '0;
      wid_q <= '0;
      out_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      wid_q <= wid_d;
      out_q <= out_d;
    end
  end

  assign pulse_o    = out_q;
  assign finished_o = (dly_q == '0) && (wid_q == '0);

endmodule

// File: rtl/sync_sequencer.sv
// Frame-grabber synchronised trigger sequencer: waits for an fg edge, delays to t0,
// then fires NUM_CH independently delayed pulses; single-shot or continuous.
module sync_sequencer
  import sync_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    start_signal,
  input  logic                    stop_signal,
  input  logic                    mode,
  input  logic                    fg_signal,
  input  logic [CNT_W-1:0]        fg_delay,
  input  logic [NUM_CH*CNT_W-1:0] ch_delay,
  input  logic [NUM_CH*CNT_W-1:0] ch_width,
  output logic [NUM_CH-1:0]       ch_out,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             frame_count,
  output logic                    overrun,
  output sync_state_e             dbg_state_o
);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    fg_prev_q;
  logic                    fg_edge;
  sync_state_e             state_q, state_d;
  logic [CNT_W-1:0]        fg_delay_q, wait_cnt_q;
  logic [NUM_CH*CNT_W-1:0] ch_delay_q, ch_width_q;
  logic                    mode_q, overrun_q;
  logic [15:0]             frame_cnt_q;
  logic [NUM_CH-1:0]       ch_fin;
  logic                    all_fin, arm, ch_load, ch_run, frame_end;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync_q    <= '0;
      fg_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], fg_signal};
      fg_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fg_edge = sync_q[SYNC_STAGES-1] & ~fg_prev_q;
  assign all_fin = &ch_fin;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_signal) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (start_signal) state_d = ST_ARMED;
        ST_ARMED:   if (fg_edge) state_d = (fg_delay_q == '0) ? ST_RUN : ST_FG_WAIT;
        ST_FG_WAIT: if (wait_cnt_q <= CNT_W'(1)) state_d = ST_RUN;
        ST_RUN:     if (all_fin) state_d = mode_q ? ST_ARMED : ST_DONE;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Channels load on the edge into RUN so their registered outputs are already valid at t0.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    dbg_state_o = state_q;
    arm         = (state_q == ST_IDLE) && (state_d == ST_ARMED);
    ch_load     = (state_q != ST_RUN) && (state_d == ST_RUN);
    ch_run      = (state_q == ST_RUN) && (state_d == ST_RUN);
    frame_end   = (state_q == ST_RUN) && all_fin && !stop_signal;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      fg_delay_q  <= '0;
      ch_delay_q  <= '0;
      ch_width_q  <= '0;
      mode_q      <= 1'b0;
      wait_cnt_q  <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (arm) begin
        fg_delay_q  <= fg_delay;
        ch_delay_q  <= ch_delay;
        ch_width_q  <= ch_width;
        mode_q      <= mode;
        frame_cnt_q <= '0;
        overrun_q   <= 1'b0;
      end else begin
        if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
        if (fg_edge && (state_q == ST_FG_WAIT || state_q == ST_RUN)) overrun_q <= 1'b1;
      end
      if (state_q == ST_ARMED && state_d == ST_FG_WAIT) begin
        wait_cnt_q <= fg_delay_q;
      end else if (state_q == ST_FG_WAIT && wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sync_pulse_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i      (CLOCK_50),
      .rst_n_i    (reset_n),
      .load_i     (ch_load),
      .run_i      (ch_run),
      .delay_i    (ch_delay_q[k*CNT_W +: CNT_W]),
      .width_i    (ch_width_q[k*CNT_W +: CNT_W]),
      .pulse_o    (ch_out[k]),
      .finished_o (ch_fin[k])
    );
  end

  assign frame_count = frame_cnt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sync_sequencer.sv
// Self-checking bench for sync_sequencer: directed cases plus randomized frames checked
// against a schedule model (t0 from fg edge, pulse windows from delay/width arithmetic).
module tb_sync_sequencer;
  import sync_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;
  localparam int SYNC   = 2;

  logic                    CLOCK_50 = 1'b0;
  logic                    reset_n, start_signal, stop_signal, mode, fg_signal;
  logic [CNT_W-1:0]        fg_delay;
  logic [NUM_CH*CNT_W-1:0] ch_delay, ch_width;
  logic [NUM_CH-1:0]       ch_out;
  logic                    busy, done, overrun;
  logic [15:0]             frame_count;
  sync_state_e             dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int m_fgd;
  int m_d[NUM_CH];
  int m_w[NUM_CH];
  int m_frames;
  bit m_ovr;

  sync_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .start_signal (start_signal),
    .stop_signal  (stop_signal),
    .mode         (mode),
    .fg_signal    (fg_signal),
    .fg_delay     (fg_delay),
    .ch_delay     (ch_delay),
    .ch_width     (ch_width),
    .ch_out       (ch_out),
    .busy         (busy),
    .done         (done),
    .frame_count  (frame_count),
    .overrun      (overrun),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // schedule model
  function automatic logic [NUM_CH-1:0] pulses_at(input int rel);
    logic [NUM_CH-1:0] p;
    p = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (m_w[k] > 0 && rel >= m_d[k] && rel < m_d[k] + m_w[k]) p[k] = 1'b1;
    return p;
  endfunction

  function automatic int run_len();
    int r;
    r = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (m_w[k] > 0 && m_d[k] + m_w[k] > r) r = m_d[k] + m_w[k];
    return r;
  endfunction

  task automatic set_cfg(input int fgd, input int d0, input int d1, input int w0, input int w1);
    m_fgd = fgd;
    m_d[0] = d0; m_d[1] = d1;
    m_w[0] = w0; m_w[1] = w1;
  endtask

  task automatic rand_cfg();
    m_fgd = $urandom_range(0, 20);
    for (int k = 0; k < NUM_CH; k++) begin
      m_d[k] = $urandom_range(0, 30);
      m_w[k] = $urandom_range(0, 12);
    end
  endtask

  // driver tasks
  task automatic arm(input bit md, input bit hold_start);
    fg_delay = CNT_W'(m_fgd);
    for (int k = 0; k < NUM_CH; k++) begin
      ch_delay[k*CNT_W +: CNT_W] = CNT_W'(m_d[k]);
      ch_width[k*CNT_W +: CNT_W] = CNT_W'(m_w[k]);
    end
    mode = md;
    start_signal = 1'b1;
    @(posedge CLOCK_50); #1;
    if (!hold_start) start_signal = 1'b0;
    fg_delay = $urandom();
    ch_delay = {$urandom(), $urandom()};
    ch_width = {$urandom(), $urandom()};
    mode = ~md;
    m_frames = 0;
    m_ovr = 1'b0;
    check_eq("arm_busy", 64'(busy), 64'(1));
    check_eq("arm_frame_count", 64'(frame_count), 64'(m_frames));
    check_eq("arm_overrun", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic idle_cycles(input int n, input bit exp_busy);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      check_eq("idle_ch_out", 64'(ch_out), 64'(0));
      check_eq("idle_done", 64'(done), 64'(0));
      check_eq("idle_busy", 64'(busy), 64'(exp_busy));
      @(posedge CLOCK_50); #1;
    end
  endtask

  // One frame from an fg pulse driven at local cycle 0; optional second fg pulse inside RUN.
  task automatic run_frame(input bit single, input bit inject);
    logic [NUM_CH-1:0] exp_q[$];
    logic [NUM_CH-1:0] e;
    int t0, tend, last, p2;
    t0   = SYNC + 1 + m_fgd;
    tend = t0 + run_len();
    last = single ? tend + 2 : tend + 1;
    if (run_len() < SYNC) inject = 1'b0;
    p2 = inject ? t0 : -100;
    for (int n = 0; n <= last; n++) exp_q.push_back((n >= t0) ? pulses_at(n - t0) : '0);
    for (int n = 0; n <= last; n++) begin
      fg_signal = (n < 2) || (n >= p2 && n < p2 + 2);
      @(negedge CLOCK_50);
      e = exp_q.pop_front();
      check_eq("ch_out", 64'(ch_out), 64'(e));
      check_eq("busy", 64'(busy), 64'(!(single && n == tend + 2)));
      check_eq("done", 64'(done), 64'(single && n == tend + 1));
      if (n == last) begin
        m_frames++;
        m_ovr = m_ovr | inject;
        check_eq("frame_count", 64'(frame_count), 64'(m_frames));
        check_eq("overrun", 64'(overrun), 64'(m_ovr));
      end
      @(posedge CLOCK_50); #1;
    end
    fg_signal = 1'b0;
  endtask

  task automatic stop_now();
    stop_signal = 1'b1;
    @(posedge CLOCK_50); #1;
    stop_signal = 1'b0;
    check_eq("stop_state", 64'(dbg_state), 64'(ST_IDLE));
    check_eq("stop_busy", 64'(busy), 64'(0));
    check_eq("stop_ch_out", 64'(ch_out), 64'(0));
    check_eq("stop_done", 64'(done), 64'(0));
    check_eq("stop_frame_count", 64'(frame_count), 64'(m_frames));
    idle_cycles(4, 1'b0);
  endtask

  task automatic run_stop(input int stop_at);
    int t0;
    t0 = SYNC + 1 + m_fgd;
    for (int n = 0; n < stop_at; n++) begin
      fg_signal = (n < 2);
      @(negedge CLOCK_50);
      check_eq("pre_stop_ch_out", 64'(ch_out), 64'((n >= t0) ? pulses_at(n - t0) : '0));
      @(posedge CLOCK_50); #1;
    end
    @(negedge CLOCK_50);
    check_eq("at_stop_ch_out", 64'(ch_out), 64'((stop_at >= t0) ? pulses_at(stop_at - t0) : '0));
    @(posedge CLOCK_50); #1;
    stop_now();
  endtask

  initial begin
    int t0;
    reset_n = 1'b0; start_signal = 1'b0; stop_signal = 1'b0; mode = 1'b0;
    fg_signal = 1'b0; fg_delay = '0; ch_delay = '0; ch_width = '0;
    m_frames = 0; m_ovr = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_eq("rst_ch_out", 64'(ch_out), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_frame_count", 64'(frame_count), 64'(0));
    check_eq("rst_overrun", 64'(overrun), 64'(0));
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;
    idle_cycles(2, 1'b0);

    // basic single frame
    set_cfg(10, 0, 5, 2, 3);
    arm(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);
    idle_cycles(3, 1'b0);

    // fg edge during RUN
    arm(1'b0, 1'b0);
    run_frame(1'b1, 1'b1);
    idle_cycles(3, 1'b0);

    // stop at t0+6
    arm(1'b0, 1'b0);
    run_stop(SYNC + 1 + m_fgd + 6);

    // zero widths, zero fg delay
    set_cfg(0, 4, 7, 0, 0);
    arm(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);
    idle_cycles(3, 1'b0);

    // continuous mode, edges 200 cycles apart
    set_cfg(10, 0, 5, 2, 3);
    arm(1'b1, 1'b0);
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 1'b0);
      if (f < 2) idle_cycles(200 - (SYNC + 1 + m_fgd + run_len() + 2), 1'b1);
    end
    stop_now();

    // randomized frames
    for (int it = 0; it < 10; it++) begin
      rand_cfg();
      if ($urandom_range(0, 1) == 1) begin
        arm(1'b0, 1'b0);
        run_frame(1'b1, 1'($urandom_range(0, 1)));
        idle_cycles(3, 1'b0);
      end else begin
        arm(1'b1, 1'b0);
        for (int f = 0; f < 2; f++) begin
          run_frame(1'b0, 1'($urandom_range(0, 1)));
          idle_cycles($urandom_range(1, 20), 1'b1);
        end
        stop_now();
      end
    end

    // start held through DONE re-arms after one IDLE cycle
    set_cfg(0, 0, 0, 0, 0);
    arm(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);
    check_eq("rearm_busy", 64'(busy), 64'(1));
    check_eq("rearm_frame_count", 64'(frame_count), 64'(0));
    start_signal = 1'b0;
    m_frames = 0;
    stop_now();

    // reset mid FG_WAIT
    set_cfg(12, 0, 5, 4, 3);
    arm(1'b1, 1'b0);
    run_frame(1'b0, 1'b1);
    for (int n = 0; n <= SYNC + 3; n++) begin
      fg_signal = (n < 2);
      if (n == SYNC + 3) reset_n = 1'b0;
      @(negedge CLOCK_50);
      check_eq("pre_rst_busy", 64'(busy), 64'(1));
      @(posedge CLOCK_50); #1;
    end
    reset_n = 1'b1;
    check_eq("mid_rst_ch_out", 64'(ch_out), 64'(0));
    check_eq("mid_rst_busy", 64'(busy), 64'(0));
    check_eq("mid_rst_done", 64'(done), 64'(0));
    check_eq("mid_rst_frame_count", 64'(frame_count), 64'(0));
    check_eq("mid_rst_overrun", 64'(overrun), 64'(0));
    check_eq("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    t0 = 0;
    fg_signal = 1'b1;
    idle_cycles(2, 1'b0);
    fg_signal = 1'b0;
    idle_cycles(40, 1'b0);
    check_eq("post_rst_frame_count", 64'(frame_count), 64'(t0));
    check_eq("post_rst_overrun", 64'(overrun), 64'(0));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
